// File: rtl/atto_pkg.sv
// Shared constants for the atto buffered router: strobe codes, port indices
// and default parameter values.
package atto_pkg;

    localparam int DATA_W_DEF     = 48;
    localparam int HDR_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [1:0] DP_01 = 2'b01;
    localparam logic [1:0] DP_10 = 2'b10;

    // Input side uses NORTH/EAST/PE, output side uses SOUTH/WEST/PE.
    localparam logic [1:0] NORTH = 2'd0;
    localparam logic [1:0] EAST  = 2'd1;
    localparam logic [1:0] PE    = 2'd2;
    localparam logic [1:0] SOUTH = 2'd0;
    localparam logic [1:0] WEST  = 2'd1;

endpackage

// File: rtl/atto_fifo.sv
// Per-input flit buffer: power-of-two depth, accepts a push while full
// when the same edge pops.
module atto_fifo
    import atto_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is not reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/atto_buffered_router.sv
// Three-input buffered mesh router with two-phase strobe/toggle-ack links,
// XY routing and a round-robin arbiter per output.
module atto_buffered_router
    import atto_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int HDR_W      = HDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clka,
    input  logic                    rsta,
    input  logic [DATA_W-1:0]       north_channel_din,
    input  logic [DATA_W-1:0]       east_channel_din,
    input  logic [DATA_W-1:0]       pe_channel_din,
    input  logic [1:0]              north_diff_pair_din,
    input  logic [1:0]              east_diff_pair_din,
    input  logic [1:0]              pe_diff_pair_din,
    output logic                    north_ack_dout,
    output logic                    east_ack_dout,
    output logic                    r2pe_ack_dout,
    output logic [DATA_W-1:0]       south_channel_dout,
    output logic [DATA_W-1:0]       west_channel_dout,
    output logic [DATA_W-HDR_W-1:0] pe_channel_dout,
    output logic [1:0]              south_diff_pair_dout,
    output logic [1:0]              west_diff_pair_dout,
    output logic [1:0]              pe_diff_pair_dout,
    input  logic                    south_ack_din,
    input  logic                    west_ack_din,
    input  logic                    pe_ack_din
);

    localparam int CW = HDR_W / 2;
    localparam int PW = DATA_W - HDR_W;

    logic [DATA_W-1:0] in_data   [3];
    logic [1:0]        in_pair   [3];
    logic [1:0]        last_code [3];
    logic [DATA_W-1:0] head      [3];
    logic [1:0]        dest      [3];
    logic [2:0]        in_ack;
    logic [2:0]        accept;
    logic [2:0]        pop;
    logic [2:0]        empty;
    logic [2:0]        full;

    logic [1:0]        out_pair  [3];
    logic [1:0]        grant_src [3];
    logic [1:0]        prio      [3];
    logic [2:0]        out_ack;
    logic [2:0]        ack_copy;
    logic [2:0]        pending;
    logic [2:0]        grant;
    logic [DATA_W-1:0] south_q;
    logic [DATA_W-1:0] west_q;
    logic [PW-1:0]     pe_q;

    assign in_data[NORTH] = north_channel_din;
    assign in_data[EAST]  = east_channel_din;
    assign in_data[PE]    = pe_channel_din;
    assign in_pair[NORTH] = north_diff_pair_din;
    assign in_pair[EAST]  = east_diff_pair_din;
    assign in_pair[PE]    = pe_diff_pair_din;
    assign out_ack[SOUTH] = south_ack_din;
    assign out_ack[WEST]  = west_ack_din;
    assign out_ack[PE]    = pe_ack_din;

    assign north_ack_dout       = in_ack[NORTH];
    assign east_ack_dout        = in_ack[EAST];
    assign r2pe_ack_dout        = in_ack[PE];
    assign south_channel_dout   = south_q;
    assign west_channel_dout    = west_q;
    assign pe_channel_dout      = pe_q;
    assign south_diff_pair_dout = out_pair[SOUTH];
    assign west_diff_pair_dout  = out_pair[WEST];
    assign pe_diff_pair_dout    = out_pair[PE];

    function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, step};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [1:0] route(input logic [DATA_W-1:0] f);
        if (f[DATA_W-1 -: CW] != '0)      return WEST;
        if (f[DATA_W-1-CW -: CW] != '0)   return SOUTH;
        return PE;
    endfunction

    function automatic logic [DATA_W-1:0] dec_x(input logic [DATA_W-1:0] f);
        logic [DATA_W-1:0] r;
        r = f;
        r[DATA_W-1 -: CW] = f[DATA_W-1 -: CW] - CW'(1);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] dec_y(input logic [DATA_W-1:0] f);
        logic [DATA_W-1:0] r;
        r = f;
        r[DATA_W-1-CW -: CW] = f[DATA_W-1-CW -: CW] - CW'(1);
        return r;
    endfunction

    // A pop at this edge frees a slot, so a full FIFO may still accept.
    for (genvar i = 0; i < 3; i++) begin : g_in
        assign accept[i] = (in_pair[i] == DP_01 || in_pair[i] == DP_10) &&
                           (in_pair[i] != last_code[i]) && (!full[i] || pop[i]);
        assign dest[i]   = route(head[i]);

        atto_fifo #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clka),
            .rst_n(rsta),
            .push (accept[i]),
            .din  (in_data[i]),
            .pop  (pop[i]),
            .dout (head[i]),
            .empty(empty[i]),
            .full (full[i])
        );
    end

    always_comb begin
        grant = '0;
        pop   = '0;
        for (int o = 0; o < 3; o++) grant_src[o] = NORTH;
        for (int o = 0; o < 3; o++) begin
            for (int k = 0; k < 3; k++) begin
                if (!pending[o] && !grant[o] &&
                    !empty[rr_next(prio[o], 2'(k))] &&
                    dest[rr_next(prio[o], 2'(k))] == 2'(o)) begin
                    grant[o]     = 1'b1;
                    grant_src[o] = rr_next(prio[o], 2'(k));
                    pop[rr_next(prio[o], 2'(k))] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            south_q <= '0;
            west_q  <= '0;
            pe_q    <= '0;
        end else begin
            if (grant[SOUTH]) south_q <= dec_y(head[grant_src[SOUTH]]);
            if (grant[WEST])  west_q  <= dec_x(head[grant_src[WEST]]);
            if (grant[PE])    pe_q    <= head[grant_src[PE]][PW-1:0];
        end
    end

    // Grant requires idle, so grant and ack-return never coincide on one output.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            in_ack   <= '0;
            ack_copy <= '0;
            pending  <= '0;
            for (int i = 0; i < 3; i++) begin
                last_code[i] <= DP_10;
                out_pair[i]  <= DP_10;
                prio[i]      <= NORTH;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) begin
                    last_code[i] <= in_pair[i];
                    in_ack[i]    <= ~in_ack[i];
                end
            end
            for (int o = 0; o < 3; o++) begin
                if (grant[o]) begin
                    out_pair[o] <= ~out_pair[o];
                    pending[o]  <= 1'b1;
                    prio[o]     <= rr_next(grant_src[o], 2'd1);
                end else if (pending[o] && (out_ack[o] != ack_copy[o])) begin
                    pending[o]  <= 1'b0;
                    ack_copy[o] <= out_ack[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_atto_buffered_router.sv
// Directed bench for atto_buffered_router with a per-output scoreboard.
module tb_atto_buffered_router;

    localparam int DW = 48;
    localparam int PW = 40;

    logic          clka = 1'b0;
    logic          rsta = 1'b0;
    logic [DW-1:0] din      [3];
    logic [1:0]    dpair    [3];
    logic [2:0]    ack_din;
    logic [2:0]    ack_o;
    logic [DW-1:0] south_d, west_d;
    logic [PW-1:0] pe_d;
    logic [1:0]    sp, wp, pp;
    logic [1:0]    out_pair [3];
    logic [DW-1:0] out_data [3];

    always #5 clka = ~clka;

    atto_buffered_router dut (
        .clka                (clka),
        .rsta                (rsta),
        .north_channel_din   (din[0]),
        .east_channel_din    (din[1]),
        .pe_channel_din      (din[2]),
        .north_diff_pair_din (dpair[0]),
        .east_diff_pair_din  (dpair[1]),
        .pe_diff_pair_din    (dpair[2]),
        .north_ack_dout      (ack_o[0]),
        .east_ack_dout       (ack_o[1]),
        .r2pe_ack_dout       (ack_o[2]),
        .south_channel_dout  (south_d),
        .west_channel_dout   (west_d),
        .pe_channel_dout     (pe_d),
        .south_diff_pair_dout(sp),
        .west_diff_pair_dout (wp),
        .pe_diff_pair_dout   (pp),
        .south_ack_din       (ack_din[0]),
        .west_ack_din        (ack_din[1]),
        .pe_ack_din          (ack_din[2])
    );

    assign out_pair[0] = sp;
    assign out_pair[1] = wp;
    assign out_pair[2] = pp;
    assign out_data[0] = south_d;
    assign out_data[1] = west_d;
    assign out_data[2] = {8'h00, pe_d};

    int            errors = 0;
    int            checks = 0;
    logic [1:0]    tb_code  [3];
    logic [1:0]    exp_pair [3];
    logic [1:0]    prev_pair[3];
    logic [2:0]    exp_ack;
    bit            auto_ack [3];
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_w[$];
    logic [DW-1:0] q_p[$];
    logic [DW-1:0] mon_exp;
    bit            mon_got;

    function automatic logic [DW-1:0] model_out(input logic [DW-1:0] f);
        logic [3:0] x, y;
        x = f[47:44];
        y = f[43:40];
        if (x != 4'd0) return {x - 4'd1, f[43:0]};
        if (y != 4'd0) return {x, y - 4'd1, f[39:0]};
        return {8'h00, f[39:0]};
    endfunction

    function automatic int model_port(input logic [DW-1:0] f);
        if (f[47:44] != 4'd0) return 1;
        if (f[43:40] != 4'd0) return 0;
        return 2;
    endfunction

    task automatic drive_flit(input int p, input logic [DW-1:0] data);
        din[p]     = data;
        tb_code[p] = (tb_code[p] == 2'b01) ? 2'b10 : 2'b01;
        dpair[p]   = tb_code[p];
        case (model_port(data))
            0:       q_s.push_back(model_out(data));
            1:       q_w.push_back(model_out(data));
            default: q_p.push_back(model_out(data));
        endcase
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic flush_state();
        for (int p = 0; p < 3; p++) begin
            dpair[p]    = 2'b10;
            tb_code[p]  = 2'b10;
            exp_pair[p] = 2'b10;
            din[p]      = '0;
        end
        ack_din = 3'b000;
        exp_ack = 3'b000;
        q_s.delete();
        q_w.delete();
        q_p.delete();
    endtask

    task automatic apply_reset();
        @(negedge clka);
        #1;
        rsta = 1'b0;
        flush_state();
        repeat (2) @(posedge clka);
        @(negedge clka);
        rsta = 1'b1;
    endtask

    // Scoreboard: each strobe flip pops the oldest expected flit of that output.
    always @(negedge clka) begin
        if (rsta === 1'b1) begin
            for (int o = 0; o < 3; o++) begin
                if (out_pair[o] !== prev_pair[o]) begin
                    mon_got = 1'b0;
                    case (o)
                        0: if (q_s.size() > 0) begin mon_exp = q_s.pop_front(); mon_got = 1'b1; end
                        1: if (q_w.size() > 0) begin mon_exp = q_w.pop_front(); mon_got = 1'b1; end
                        default: if (q_p.size() > 0) begin mon_exp = q_p.pop_front(); mon_got = 1'b1; end
                    endcase
                    checks++;
                    if (!mon_got) begin
                        errors++;
                        $display("FAIL strobe_unexpected out=%0d data=%h want no strobe", o, out_data[o]);
                    end else if (out_data[o] !== mon_exp) begin
                        errors++;
                        $display("FAIL scoreboard_data out=%0d got %h want %h", o, out_data[o], mon_exp);
                    end
                    if (auto_ack[o]) ack_din[o] = ~ack_din[o];
                end
            end
        end
        for (int o = 0; o < 3; o++) prev_pair[o] = out_pair[o];
    end

    task automatic test_reset();
        flush_state();
        for (int o = 0; o < 3; o++) auto_ack[o] = 1'b1;
        rsta = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        for (int o = 0; o < 3; o++) begin
            checks++;
            if (out_data[o] !== '0) begin
                errors++;
                $display("FAIL reset_data out=%0d got %h want 0", o, out_data[o]);
            end
            checks++;
            if (out_pair[o] !== 2'b10) begin
                errors++;
                $display("FAIL reset_pair out=%0d got %b want 10", o, out_pair[o]);
            end
        end
        checks++;
        if (ack_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_ack got %b want 000", ack_o);
        end
        @(negedge clka);
        rsta = 1'b1;
        tick();
    endtask

    task automatic test_west_route();
        @(negedge clka);
        drive_flit(0, 48'h210000000000);
        exp_ack[0] = ~exp_ack[0];
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL west_ack_at_accept got %b want %b", ack_o, exp_ack);
        end
        checks++;
        if (out_pair[1] !== exp_pair[1]) begin
            errors++;
            $display("FAIL west_pair_early got %b want %b", out_pair[1], exp_pair[1]);
        end
        tick();
        exp_pair[1] = ~exp_pair[1];
        checks++;
        if (out_pair[1] !== exp_pair[1]) begin
            errors++;
            $display("FAIL west_pair_flip got %b want %b", out_pair[1], exp_pair[1]);
        end
        checks++;
        if (west_d !== 48'h110000000000) begin
            errors++;
            $display("FAIL west_data got %h want 110000000000", west_d);
        end
        repeat (4) tick();
    endtask

    task automatic test_south_pe();
        @(negedge clka);
        drive_flit(1, 48'h011111111111);
        exp_ack[1] = ~exp_ack[1];
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL south_ack got %b want %b", ack_o, exp_ack);
        end
        tick();
        exp_pair[0] = ~exp_pair[0];
        checks++;
        if (out_pair[0] !== exp_pair[0] || south_d !== 48'h001111111111) begin
            errors++;
            $display("FAIL south_route got pair=%b data=%h want pair=%b data=001111111111",
                     out_pair[0], south_d, exp_pair[0]);
        end
        repeat (3) tick();
        @(negedge clka);
        drive_flit(1, 48'h00AAAAAAAAAA);
        exp_ack[1] = ~exp_ack[1];
        tick();
        tick();
        exp_pair[2] = ~exp_pair[2];
        checks++;
        if (out_pair[2] !== exp_pair[2] || pe_d !== 40'hAAAAAAAAAA) begin
            errors++;
            $display("FAIL pe_eject got pair=%b data=%h want pair=%b data=AAAAAAAAAA",
                     out_pair[2], pe_d, exp_pair[2]);
        end
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL pe_path_ack got %b want %b", ack_o, exp_ack);
        end
        repeat (3) tick();
    endtask

    task automatic test_all_three();
        @(negedge clka);
        drive_flit(0, 48'h1100000000C1);
        drive_flit(1, 48'h0200000000C2);
        drive_flit(2, 48'h0000000000C3);
        exp_ack = ~exp_ack;
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL all_accept got %b want %b", ack_o, exp_ack);
        end
        tick();
        for (int o = 0; o < 3; o++) begin
            exp_pair[o] = ~exp_pair[o];
            checks++;
            if (out_pair[o] !== exp_pair[o]) begin
                errors++;
                $display("FAIL all_grant out=%0d got %b want %b", o, out_pair[o], exp_pair[o]);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_arbitration();
        apply_reset();
        @(negedge clka);
        #1;
        auto_ack[1] = 1'b0;
        drive_flit(0, 48'h2100000000AA);
        drive_flit(1, 48'h3200000000BB);
        exp_ack = exp_ack ^ 3'b011;
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL arb_accept got %b want %b", ack_o, exp_ack);
        end
        tick();
        exp_pair[1] = ~exp_pair[1];
        checks++;
        if (out_pair[1] !== exp_pair[1] || west_d !== 48'h1100000000AA) begin
            errors++;
            $display("FAIL arb_first got pair=%b data=%h want pair=%b data=1100000000AA",
                     out_pair[1], west_d, exp_pair[1]);
        end
        repeat (3) tick();
        checks++;
        if (out_pair[1] !== exp_pair[1] || west_d !== 48'h1100000000AA) begin
            errors++;
            $display("FAIL arb_hold got pair=%b data=%h want pair=%b data=1100000000AA",
                     out_pair[1], west_d, exp_pair[1]);
        end
        @(negedge clka);
        #1;
        ack_din[1] = ~ack_din[1];
        tick();
        checks++;
        if (out_pair[1] !== exp_pair[1]) begin
            errors++;
            $display("FAIL arb_idle_edge got %b want %b", out_pair[1], exp_pair[1]);
        end
        tick();
        exp_pair[1] = ~exp_pair[1];
        checks++;
        if (out_pair[1] !== exp_pair[1] || west_d !== 48'h2200000000BB) begin
            errors++;
            $display("FAIL arb_second got pair=%b data=%h want pair=%b data=2200000000BB",
                     out_pair[1], west_d, exp_pair[1]);
        end
        @(negedge clka);
        #1;
        auto_ack[1] = 1'b1;
        ack_din[1]  = ~ack_din[1];
        repeat (3) tick();
    endtask

    task automatic test_fifo_full();
        @(negedge clka);
        #1;
        auto_ack[1] = 1'b0;
        drive_flit(0, 48'h1000000000F0);
        exp_ack[0] = ~exp_ack[0];
        tick();
        tick();
        exp_pair[1] = ~exp_pair[1];
        checks++;
        if (out_pair[1] !== exp_pair[1]) begin
            errors++;
            $display("FAIL full_blocker got %b want %b", out_pair[1], exp_pair[1]);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clka);
            drive_flit(0, 48'h1000000000F0 + 48'(k));
            exp_ack[0] = ~exp_ack[0];
            tick();
            checks++;
            if (ack_o[0] !== exp_ack[0]) begin
                errors++;
                $display("FAIL full_fill_ack k=%0d got %b want %b", k, ack_o[0], exp_ack[0]);
            end
        end
        @(negedge clka);
        drive_flit(0, 48'h1000000000F5);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ack_o[0] !== exp_ack[0]) begin
                errors++;
                $display("FAIL full_withheld cyc=%0d got %b want %b", k, ack_o[0], exp_ack[0]);
            end
        end
        @(negedge clka);
        #1;
        auto_ack[1] = 1'b1;
        ack_din[1]  = ~ack_din[1];
        tick();
        checks++;
        if (ack_o[0] !== exp_ack[0]) begin
            errors++;
            $display("FAIL full_early_accept got %b want %b", ack_o[0], exp_ack[0]);
        end
        tick();
        exp_ack[0] = ~exp_ack[0];
        checks++;
        if (ack_o[0] !== exp_ack[0]) begin
            errors++;
            $display("FAIL full_accept_on_pop got %b want %b", ack_o[0], exp_ack[0]);
        end
        repeat (14) tick();
    endtask

    task automatic test_illegal_code();
        @(negedge clka);
        din[0]   = 48'h2100000000EE;
        dpair[0] = 2'b11;
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL illegal_11 got %b want %b", ack_o, exp_ack);
        end
        @(negedge clka);
        dpair[0] = 2'b00;
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL illegal_00 got %b want %b", ack_o, exp_ack);
        end
        @(negedge clka);
        dpair[0] = tb_code[0];
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL illegal_same_code got %b want %b", ack_o, exp_ack);
        end
        @(negedge clka);
        drive_flit(0, 48'h2100000000EE);
        exp_ack[0] = ~exp_ack[0];
        tick();
        checks++;
        if (ack_o !== exp_ack) begin
            errors++;
            $display("FAIL illegal_then_legal got %b want %b", ack_o, exp_ack);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        @(negedge clka);
        #1;
        auto_ack[1] = 1'b0;
        drive_flit(0, 48'h2100000000D1);
        tick();
        tick();
        @(negedge clka);
        drive_flit(0, 48'h2100000000D2);
        tick();
        @(negedge clka);
        drive_flit(0, 48'h2100000000D3);
        tick();
        @(negedge clka);
        #1;
        rsta = 1'b0;
        flush_state();
        #1;
        checks++;
        if (west_d !== '0 || wp !== 2'b10 || ack_o !== 3'b000) begin
            errors++;
            $display("FAIL midreset_outputs got data=%h pair=%b ack=%b want 0/10/000", west_d, wp, ack_o);
        end
        repeat (2) @(posedge clka);
        @(negedge clka);
        rsta = 1'b1;
        auto_ack[1] = 1'b1;
        repeat (10) tick();
        for (int o = 0; o < 3; o++) begin
            checks++;
            if (out_pair[o] !== 2'b10) begin
                errors++;
                $display("FAIL midreset_no_strobe out=%0d got %b want 10", o, out_pair[o]);
            end
        end
        checks++;
        if (ack_o !== 3'b000) begin
            errors++;
            $display("FAIL midreset_ack got %b want 000", ack_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_west_route();
        test_south_pe();
        test_all_three();
        test_arbitration();
        test_fifo_full();
        test_illegal_code();
        test_reset_mid();
        checks++;
        if (q_s.size() + q_w.size() + q_p.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d pending want 0", q_s.size() + q_w.size() + q_p.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/atto_buffered_router.md
ATTO_BUFFERED_ROUTER -- requirements
Module: atto_buffered_router

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: clka and rsta, rsta active-low, asynchronous assertion.
REQ-002 Parameters SHALL be:
- DATA_W, default 48, flit width.
- HDR_W, default 8, header width in flit bits [DATA_W-1 -: HDR_W].
- FIFO_DEPTH, default 4, per-input buffer depth, power of two, at least 2.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- clka, in, 1, clock.
- rsta, in, 1, async active-low reset.
- north_channel_din / east_channel_din / pe_channel_din, in, DATA_W, input flits.
- north_diff_pair_din / east_diff_pair_din / pe_diff_pair_din, in, 2, two-phase flit strobe.
- north_ack_dout / east_ack_dout / r2pe_ack_dout, out, 1, toggle when a flit is accepted.
- south_channel_dout / west_channel_dout, out, DATA_W, forwarded flits.
- pe_channel_dout, out, DATA_W-HDR_W, ejected payload with header stripped.
- south_diff_pair_dout / west_diff_pair_dout / pe_diff_pair_dout, out, 2, two-phase flit strobe.
- south_ack_din / west_ack_din / pe_ack_din, in, 1, downstream accept toggle.

Function
REQ-004 Diff-pair legal codes SHALL be 2'b01 and 2'b10; a new flit is signalled by a change from one legal code to the other; 2'b00/2'b11 SHALL be ignored and leave the last-seen code unchanged.
REQ-005 On a clka edge with a new flit and a non-full input FIFO, the flit SHALL be written, the last-seen code updated and the port ack toggled at that same edge.
REQ-006 With the FIFO full, the flit SHALL NOT be accepted, and neither the last-seen code nor the ack SHALL change; acceptance occurs at the first edge the FIFO is non-full.
REQ-007 Routing SHALL be dimension-ordered on the head flit: header X=[DATA_W-1 -: HDR_W/2], Y=[DATA_W-1-HDR_W/2 -: HDR_W/2], unsigned.
- X != 0: route west, X decremented.
- X == 0, Y != 0: route south, Y decremented.
- X == Y == 0: route to PE, header stripped.
REQ-008 Each output SHALL hold a round-robin arbiter over inputs (order north, east, pe). After a grant, priority SHALL move to the input after the winner; with no grant, priority SHALL stay unchanged.
REQ-009 An output SHALL be eligible for grant only when idle, i.e. no flit pending downstream ack.
REQ-010 On a grant:
- the flit (rewritten header) SHALL be registered onto the output channel;
- the output diff pair SHALL flip code;
- the output SHALL become pending;
- the winning FIFO SHALL pop at the same edge.
REQ-011 A pending output SHALL return to idle at the edge where its ack_din differs from its registered ack copy; the copy SHALL then update. An output may be re-granted at the edge following its return to idle.
REQ-012 Channel data SHALL remain stable while the output is pending.
REQ-013 Minimum latency SHALL be 2 clka edges: accept at edge N, output diff-pair flip at edge N+1.
REQ-014 Simultaneous push and pop on one FIFO SHALL both take effect, including when full (pop frees the slot; push accepted same edge) and when empty (push only; pop impossible). Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 All three inputs accepting at the same edge, and all three outputs granting at the same edge, SHALL be supported.

Reset
REQ-016 While rsta is low:
- all channel outputs SHALL be 0;
- all diff_pair_dout SHALL be 2'b10;
- all ack_dout SHALL be 0;
- input last-seen codes SHALL be 2'b10;
- ack copies SHALL be 0;
- FIFOs SHALL be empty;
- outputs SHALL be idle;
- arbiter priority SHALL point to north.
REQ-017 Reset asserted mid-transfer SHALL discard all buffered and pending flits without emitting further strobes.

Structure
REQ-018 The shared package atto_pkg SHALL hold the diff-pair codes DP_01/DP_10, the port-index constants (NORTH, EAST, PE, SOUTH, WEST) and the default parameter values.
REQ-019 The per-input buffer SHALL be the sub-module atto_fifo (DATA_W, FIFO_DEPTH), instantiated three times.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- North 48'h210000000000, pair 10->01: west_channel_dout=48'h110000000000 and west pair flips 2 edges later; north_ack_dout toggles at the accept edge.
- East 48'h001111111111: south_channel_dout=48'h001111111111 with Y decremented to 0; then 48'h00AAAAAAAAAA: pe_channel_dout=40'hAAAAAAAAAA.
- North and east both target west, west_ack_din held: exactly one is granted (north first), the second waits; after the ack toggle, east's flit is emitted on the next grant edge.
- West stalled, 5 flits on north with FIFO_DEPTH=4: 4 acks, the fifth ack is withheld until the first pop, and the last-seen code stays stable meanwhile.
- Pair code 2'b11 inserted between flits: no accept, no ack toggle.
- rsta asserted with 2 flits buffered and west pending: outputs return to reset values, and no strobe follows after release.
